// File: rtl/ct_spsram_512x59_ctrl_if.sv
// Request/response handshake and SRAM macro pins of the 512x59 single-port SRAM controller.
// The slave modport is the controller; the master modport is the requester plus SRAM macro.
interface ct_spsram_512x59_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 59
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        output req_rdy, rsp_vld, rsp_rdata, init_done,
        output sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        input  req_rdy, rsp_vld, rsp_rdata, init_done,
        input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );
endinterface

// File: rtl/ct_spsram_512x59_ctrl.sv
// Single-port SRAM controller: zero-fills the array after reset, then serves masked writes
// and reads through a 2-entry response FIFO with full back-to-back read throughput.
module ct_spsram_512x59_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 59
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    ct_spsram_512x59_ctrl_if.slave bus
);
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_done;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [DATA_WIDTH-1:0] r_fifo [2];

    logic                  w_init_wr;
    logic                  w_run;
    logic                  w_rsp_vld;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_req_rdy;
    logic                  w_acc;
    logic                  w_acc_rd;
    logic                  w_sram_cen;
    logic                  w_sram_gwen;
    logic [ADDR_WIDTH-1:0] w_sram_a;
    logic [DATA_WIDTH-1:0] w_sram_wen;
    logic [DATA_WIDTH-1:0] w_sram_d;

    // Outputs are gated by cpurst_b so the macro and requester see idle while reset is held.
    assign w_init_wr = cpurst_b && (r_state == ST_INIT);
    assign w_run     = cpurst_b && (r_state == ST_RUN);
    assign w_rsp_vld = cpurst_b && (r_count != 2'd0);
    assign w_pop     = w_rsp_vld && bus.rsp_rdy;
    assign w_push    = r_inflight;

    // Occupancy the FIFO will have once the read in flight lands; a new read needs one free slot.
    assign w_occ     = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_req_rdy = w_run && (w_occ < 3'd2);
    assign w_acc     = bus.req_vld && w_req_rdy;
    assign w_acc_rd  = w_acc && !bus.req_wr;

    always_comb begin
        w_sram_cen  = 1'b1;
        w_sram_gwen = 1'b1;
        w_sram_a    = '0;
        w_sram_wen  = '1;
        w_sram_d    = '0;
        if (w_init_wr) begin
            w_sram_cen  = 1'b0;
            w_sram_gwen = 1'b0;
            w_sram_a    = r_init_cnt;
            w_sram_wen  = '0;
        end else if (w_acc) begin
            w_sram_cen = 1'b0;
            w_sram_a   = bus.req_addr;
            if (bus.req_wr) begin
                w_sram_gwen = 1'b0;
                w_sram_wen  = ~bus.req_wmask;
                w_sram_d    = bus.req_wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (&r_init_cnt) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            r_inflight <= w_acc_rd;
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // sram_q is valid the cycle after the read access, which is exactly when r_inflight is set.
    always_ff @(posedge forever_cpuclk) begin
        if (w_push) r_fifo[r_wptr] <= bus.sram_q;
    end

    assign bus.req_rdy   = w_req_rdy;
    assign bus.rsp_vld   = w_rsp_vld;
    assign bus.rsp_rdata = cpurst_b ? r_fifo[r_rptr] : '0;
    assign bus.init_done = r_init_done;
    assign bus.sram_cen  = w_sram_cen;
    assign bus.sram_gwen = w_sram_gwen;
    assign bus.sram_a    = w_sram_a;
    assign bus.sram_wen  = w_sram_wen;
    assign bus.sram_d    = w_sram_d;
endmodule
